// File: rtl/seg_scan_mux.sv
// Two-digit multiplexed 7-segment scanner with blanking between digits and tear-free frame capture.
// Optional brightness gating is compiled in when SEG_SCAN_DIM_EN is defined.
module seg_scan_mux #(
    parameter int unsigned SCAN_TICKS  = 8,
    parameter int unsigned BLANK_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:6] seg_a,
    input  logic [0:6] seg_b,
`ifdef SEG_SCAN_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [0:6] seg_out,
    output logic [1:0] dig_en,
    output logic       frame_strobe
);

    localparam int unsigned MaxTicks = (SCAN_TICKS > BLANK_TICKS) ? SCAN_TICKS : BLANK_TICKS;
    localparam int unsigned CntW     = $clog2(MaxTicks);

    localparam logic [CntW-1:0] ScanLast  = CntW'(SCAN_TICKS - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_TICKS - 1);

    localparam logic [1:0] StBlankA = 2'd0;
    localparam logic [1:0] StShowA  = 2'd1;
    localparam logic [1:0] StBlankB = 2'd2;
    localparam logic [1:0] StShowB  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [0:6]      shadow_a_q, shadow_a_d;
    logic [0:6]      shadow_b_q, shadow_b_d;
    logic            strobe_q, strobe_d;
    logic [0:6]      seg_out_q, seg_out_d;
    logic [1:0]      dig_en_q, dig_en_d;
    logic            capture;
    logic            phase_last;
    logic            show_on;
`ifdef SEG_SCAN_DIM_EN
    logic [2:0]      bright_q, bright_d;
    logic [31:0]     on_ticks;
`endif

    // Sequencing, capture and strobe generation.
    always_comb begin
        capture    = (state_q == StBlankA) && (cnt_q == '0);
        phase_last = ((state_q == StBlankA) || (state_q == StBlankB)) ? (cnt_q == BlankLast)
                                                                         : (cnt_q == ScanLast);
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        if (phase_last) begin
            cnt_d = '0;
            case (state_q)
                StBlankA: state_d = StShowA;
                StShowA:  state_d = StBlankB;
                StBlankB: state_d = StShowB;
                default:  state_d = StBlankA;
            endcase
        end
        shadow_a_d = capture ? seg_a : shadow_a_q;
        shadow_b_d = capture ? seg_b : shadow_b_q;
        strobe_d   = capture;
`ifdef SEG_SCAN_DIM_EN
        bright_d   = capture ? bright : bright_q;
`endif
    end

    // Outputs are decoded from next-state values and registered, so the pins never glitch.
    always_comb begin
`ifdef SEG_SCAN_DIM_EN
        on_ticks = (32'(bright_d) + 32'd1) * 32'(SCAN_TICKS / 8);
        show_on  = 32'(cnt_d) < on_ticks;
`else
        show_on  = 1'b1;
`endif
        seg_out_d = 7'b1111111;
        dig_en_d  = 2'b11;
        case (state_d)
            StShowA: begin
                if (show_on) begin
                    seg_out_d = shadow_a_d;
                    dig_en_d  = 2'b10;
                end
            end
            StShowB: begin
                if (show_on) begin
                    seg_out_d = shadow_b_d;
                    dig_en_d  = 2'b01;
                end
            end
            default: begin
                seg_out_d = 7'b1111111;
                dig_en_d  = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBlankA;
            cnt_q      <= '0;
            shadow_a_q <= 7'b1111111;
            shadow_b_q <= 7'b1111111;
            strobe_q   <= 1'b0;
            seg_out_q  <= 7'b1111111;
            dig_en_q   <= 2'b11;
`ifdef SEG_SCAN_DIM_EN
            bright_q   <= 3'd7;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            strobe_q   <= strobe_d;
            seg_out_q  <= seg_out_d;
            dig_en_q   <= dig_en_d;
`ifdef SEG_SCAN_DIM_EN
            bright_q   <= bright_d;
`endif
        end
    end

    assign seg_out      = seg_out_q;
    assign dig_en       = dig_en_q;
    assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed frame table, tearing/reset sequences and a
// randomized run of two instances against a position-in-frame reference model.
module tb_seg_scan_mux;

    localparam int S1 = 8;
    localparam int B1 = 2;
`ifdef SEG_SCAN_DIM_EN
    localparam int S2 = 16;
    localparam int B2 = 1;
`else
    localparam int S2 = 2;
    localparam int B2 = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [0:6] seg_a, seg_b;
    logic [2:0] bright;
    logic [0:6] so1, so2;
    logic [1:0] de1, de2;
    logic       fs1, fs2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [0:6] m_sa [2];
    logic [0:6] m_sb [2];
    logic [2:0] m_br [2];
    logic [1:0] dig_seq [0:5] = '{2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01};

    typedef struct {
        int         clk_no;
        logic [0:6] a;
        logic [0:6] b;
        logic [0:6] seg;
        logic [1:0] dig;
        logic       stb;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    seg_scan_mux #(.SCAN_TICKS(S1), .BLANK_TICKS(B1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_a        (seg_a),
        .seg_b        (seg_b),
`ifdef SEG_SCAN_DIM_EN
        .bright       (bright),
`endif
        .seg_out      (so1),
        .dig_en       (de1),
        .frame_strobe (fs1)
    );

    seg_scan_mux #(.SCAN_TICKS(S2), .BLANK_TICKS(B2)) u_dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_a        (seg_a),
        .seg_b        (seg_b),
`ifdef SEG_SCAN_DIM_EN
        .bright       (bright),
`endif
        .seg_out      (so2),
        .dig_en       (de2),
        .frame_strobe (fs2)
    );

    // Expected {seg_out, dig_en, frame_strobe} from the position inside the frame.
    function automatic logic [9:0] model(int s, int b, int c, logic [0:6] sa, logic [0:6] sb,
                                         logic [2:0] br);
        int         pos = c % (2 * (s + b));
        int         on  = (int'(br) + 1) * s / 8;
        logic [0:6] seg = 7'b1111111;
        logic [1:0] dig = 2'b11;
        if (pos >= b && pos < b + s) begin
            if (pos - b < on) begin
                seg = sa;
                dig = 2'b10;
            end
        end else if (pos >= 2 * b + s && pos - (2 * b + s) < on) begin
            seg = sb;
            dig = 2'b01;
        end
        return {seg, dig, (pos == 1)};
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %b want %b", nm, cyc, act, exp);
        end
    endtask

    // Check the current cycle on both instances, update model captures, advance one clock.
    task automatic step();
        check("model1", {so1, de1, fs1}, model(S1, B1, cyc, m_sa[0], m_sb[0], m_br[0]));
        check("model2", {so2, de2, fs2}, model(S2, B2, cyc, m_sa[1], m_sb[1], m_br[1]));
`ifndef SEG_SCAN_DIM_EN
        check("dig_seq2", {8'd0, de2}, {8'd0, dig_seq[cyc % 6]});
`endif
        if (cyc % (2 * (S1 + B1)) == 0) begin
            m_sa[0] = seg_a;
            m_sb[0] = seg_b;
            m_br[0] = bright;
        end
        if (cyc % (2 * (S2 + B2)) == 0) begin
            m_sa[1] = seg_a;
            m_sb[1] = seg_b;
            m_br[1] = bright;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_table();
        for (int i = 0; i < tbl.size(); i++) begin
            while (cyc + 1 < tbl[i].clk_no) step();
            seg_a = tbl[i].a;
            seg_b = tbl[i].b;
            check($sformatf("table_clk%0d", tbl[i].clk_no), {so1, de1, fs1},
                  {tbl[i].seg, tbl[i].dig, tbl[i].stb});
        end
    endtask

    initial begin
        tbl.push_back(vec_t'{1,  7'b0001101, 7'b0000000, 7'b1111111, 2'b11, 1'b0});
        tbl.push_back(vec_t'{2,  7'b0001101, 7'b0000000, 7'b1111111, 2'b11, 1'b1});
        tbl.push_back(vec_t'{3,  7'b0001101, 7'b0000000, 7'b0001101, 2'b10, 1'b0});
        tbl.push_back(vec_t'{10, 7'b0001101, 7'b0000000, 7'b0001101, 2'b10, 1'b0});
        tbl.push_back(vec_t'{11, 7'b0001101, 7'b0000000, 7'b1111111, 2'b11, 1'b0});
        tbl.push_back(vec_t'{12, 7'b0001101, 7'b0000000, 7'b1111111, 2'b11, 1'b0});
        tbl.push_back(vec_t'{13, 7'b0001101, 7'b0000000, 7'b0000000, 2'b01, 1'b0});
        tbl.push_back(vec_t'{20, 7'b0001101, 7'b0000000, 7'b0000000, 2'b01, 1'b0});
        tbl.push_back(vec_t'{21, 7'b0001101, 7'b0000000, 7'b1111111, 2'b11, 1'b0});
        tbl.push_back(vec_t'{22, 7'b0001101, 7'b0000000, 7'b1111111, 2'b11, 1'b1});
        tbl.push_back(vec_t'{23, 7'b0001101, 7'b0000000, 7'b0001101, 2'b10, 1'b0});

        for (int i = 0; i < 2; i++) begin
            m_sa[i] = 7'b1111111;
            m_sb[i] = 7'b1111111;
            m_br[i] = 3'd7;
        end
        seg_a  = 7'b1111111;
        seg_b  = 7'b1111111;
        bright = 3'd7;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset1", {so1, de1, fs1}, {7'b1111111, 2'b11, 1'b0});
        check("reset2", {so2, de2, fs2}, {7'b1111111, 2'b11, 1'b0});

        rst_n = 1'b1;
        cyc   = 0;
        run_table();

        // Mid-SHOW_A input change must not tear the displayed frame.
        step();
        seg_a = 7'b1000011;
        for (int k = 0; k < 7; k++) begin
            check("no_tear", {so1, 3'b000}, {7'b0001101, 3'b000});
            step();
        end
        while (cyc < 42) step();
        check("next_frame", {so1, de1, 1'b0}, {7'b1000011, 2'b10, 1'b0});

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) seg_a = 7'($urandom);
            if ($urandom_range(0, 3) == 0) seg_b = 7'($urandom);
`ifdef SEG_SCAN_DIM_EN
            if ($urandom_range(0, 7) == 0) bright = 3'($urandom);
`endif
            step();
        end

        // Asynchronous reset in the middle of SHOW_B.
        while ((cyc % (2 * (S1 + B1))) != 15) step();
        check("pre_rst_showb", {8'd0, de1}, {8'd0, 2'b01});
        rst_n = 1'b0;
        #1;
        check("async_rst1", {so1, de1, fs1}, {7'b1111111, 2'b11, 1'b0});
        check("async_rst2", {so2, de2, fs2}, {7'b1111111, 2'b11, 1'b0});
        @(negedge clk);
        check("rst_hold", {so1, de1, fs1}, {7'b1111111, 2'b11, 1'b0});
        bright = 3'd7;
        for (int i = 0; i < 2; i++) begin
            m_sa[i] = 7'b1111111;
            m_sb[i] = 7'b1111111;
            m_br[i] = 3'd7;
        end
        rst_n = 1'b1;
        cyc   = 0;
        run_table();

`ifdef SEG_SCAN_DIM_EN
        for (int pass = 0; pass < 2; pass++) begin
            int n_a = 0;
            int n_b = 0;
            bright = (pass == 0) ? 3'd3 : 3'd7;
            while ((cyc % (2 * (S1 + B1))) != 0) step();
            step();
            for (int k = 0; k < 2 * (S1 + B1); k++) begin
                if (de1 == 2'b10) n_a++;
                if (de1 == 2'b01) n_b++;
                step();
            end
            check("dim_a_on", 10'(n_a), (pass == 0) ? 10'd4 : 10'd8);
            check("dim_b_on", 10'(n_b), (pass == 0) ? 10'd4 : 10'd8);
        end
`endif

        for (int i = 0; i < 30; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
